// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, memory-state encoding and opcode classifiers
// for the LC-3 pipeline controller.
package lc3_ctrl_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OP_W-1:0] OP_STR = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OP_W-1:0] OP_STI = 4'b1011;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    READ     = 2'd0,
    INDIRECT = 2'd1,
    WRITE    = 2'd2,
    IDLE     = 2'd3
  } mem_state_t;

  // Access shape of a memory instruction: direct read/write or via a pointer.
  typedef enum logic [1:0] {
    MC_READ      = 2'd0,
    MC_WRITE     = 2'd1,
    MC_IND_LOAD  = 2'd2,
    MC_IND_STORE = 2'd3
  } mem_class_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  function automatic logic is_load_op(input logic [OP_W-1:0] op);
    return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
  endfunction

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return is_load_op(op) || (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

  function automatic mem_class_t mem_class(input logic [OP_W-1:0] op);
    mem_class_t c;
    case (op)
      OP_ST, OP_STR: c = MC_WRITE;
      OP_LDI:        c = MC_IND_LOAD;
      OP_STI:        c = MC_IND_STORE;
      default:       c = MC_READ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_mem_fsm.sv
// Data-memory access sequencer: IDLE -> (INDIRECT ->) READ/WRITE -> IDLE,
// stepping on complete_data; flags the cycle a read finishes.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op_class,
  input  logic       complete_data,
  output logic [1:0] mem_state,
  output logic       wb_pulse_c
);

  mem_state_t state;
  logic       ind_store;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ind_store <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op_class)
              MC_READ:  state <= READ;
              MC_WRITE: state <= WRITE;
              default:  state <= INDIRECT;
            endcase
            ind_store <= (op_class == MC_IND_STORE);
          end
        end
        INDIRECT: if (complete_data) state <= ind_store ? WRITE : READ;
        default:  if (complete_data) state <= IDLE;
      endcase
    end
  end

  assign mem_state  = state;
  assign wb_pulse_c = (state == READ) && complete_data;

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: stage enables, branch bubbles, memory stalls and
// operand forwarding. LC3_CTRL_BYPASS_EN enables forwarding; otherwise RAW stalls.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned BR_BUBBLE = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] instr_dout,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2
);

  localparam int unsigned CNT_W = 3;

  logic             run;
  logic [3:1]       v;
  logic [CNT_W-1:0] bubble_cnt;
  logic [1:0]       br_pipe;
  logic             advance, raw_stall, mem_idle, hazard_valid, wb_pulse_c;
  logic             alu_1, alu_2, mem_1, mem_2, two_reg;
  logic             br_trigger, br_cond, mem_start;
  logic [1:0]       op_class;
  logic [3:0]       exec_op, ir_op, dout_op;
  logic             unused_bits;

  assign exec_op = ir_exec[15:12];
  assign ir_op   = ir[15:12];
  assign dout_op = instr_dout[15:12];
  assign unused_bits = ^{instr_dout[11:0], ir[11:9], ir[4:3], ir_exec[8:0]};

  // Producer in ir_exec vs. source registers of the instruction entering execute
  assign two_reg      = ((ir_op == OP_ADD) || (ir_op == OP_AND)) && !ir[5];
  assign alu_1        = is_alu_op(exec_op) && (ir_exec[11:9] == ir[8:6]);
  assign alu_2        = is_alu_op(exec_op) && two_reg && (ir_exec[11:9] == ir[2:0]);
  assign mem_1        = is_load_op(exec_op) && (ir_exec[11:9] == ir[8:6]);
  assign mem_2        = is_load_op(exec_op) && two_reg && (ir_exec[11:9] == ir[2:0]);
  assign mem_idle     = (mem_state == IDLE);
  assign hazard_valid = complete_instr && mem_idle && v[2];

`ifdef LC3_CTRL_BYPASS_EN
  assign bypass_alu_1 = hazard_valid && alu_1;
  assign bypass_alu_2 = hazard_valid && alu_2;
  assign bypass_mem_1 = hazard_valid && mem_1;
  assign bypass_mem_2 = hazard_valid && mem_2;
  assign raw_stall    = 1'b0;
`else
  logic raw_done;
  logic any_hazard;

  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
  assign bypass_mem_1 = 1'b0;
  assign bypass_mem_2 = 1'b0;
  assign any_hazard   = alu_1 || alu_2 || mem_1 || mem_2;
  assign raw_stall    = hazard_valid && any_hazard && !raw_done;

  // One bubble per hazard: remember the stall until the pipeline moves again
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         raw_done <= 1'b0;
    else if (raw_stall) raw_done <= 1'b1;
    else if (advance)   raw_done <= 1'b0;
  end
`endif

  assign advance          = complete_instr && mem_idle && !raw_stall;
  assign enable_fetch     = advance && run && (bubble_cnt == '0);
  assign enable_decode    = advance && v[1];
  assign enable_execute   = advance && v[2];
  assign enable_writeback = (advance && v[3]) || wb_pulse_c;

  assign br_trigger      = enable_decode && ((dout_op == OP_BR) || (dout_op == OP_JMP));
  assign br_cond         = (exec_op == OP_JMP) || ((exec_op == OP_BR) && |(ir_exec[11:9] & psr));
  assign br_taken        = advance && br_pipe[1] && br_cond;
  assign enable_updatePC = enable_fetch || br_taken;

  assign mem_start = enable_execute && is_mem_op(ir_op);
  assign op_class  = mem_class(ir_op);

  // Valid bits and branch markers travel with the pipeline; bubbles gate fetch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      v          <= '0;
      bubble_cnt <= '0;
      br_pipe    <= '0;
    end else begin
      run <= 1'b1;
      if (advance) begin
        v       <= {v[2:1], enable_fetch};
        br_pipe <= {br_pipe[0], br_trigger};
        if (br_trigger)              bubble_cnt <= CNT_W'(BR_BUBBLE);
        else if (bubble_cnt != '0)   bubble_cnt <= bubble_cnt - CNT_W'(1);
      end
    end
  end

  lc3_mem_fsm u_mem_fsm (
    .clock         (clock),
    .reset         (reset),
    .start         (mem_start),
    .op_class      (op_class),
    .complete_data (complete_data),
    .mem_state     (mem_state),
    .wb_pulse_c    (wb_pulse_c)
  );

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Self-checking bench for lc3_pipe_controller: directed scenarios plus random
// traffic compared against a slot/queue level reference model.
module tb_lc3_pipe_controller;

  localparam int unsigned BB   = 3;
  localparam logic [15:0] NEUT = 16'hD000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        complete_instr = 1'b0, complete_data = 1'b0;
  logic [15:0] instr_dout = NEUT, ir = NEUT, ir_exec = NEUT;
  logic [2:0]  psr = 3'b000;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [1:0]  mem_state;
  logic [11:0] got_vec;

  int tests = 0;
  int fails = 0;

  lc3_pipe_controller #(.BR_BUBBLE(BB)) dut (
    .clock(clock), .reset(reset), .complete_instr(complete_instr), .complete_data(complete_data),
    .instr_dout(instr_dout), .ir(ir), .ir_exec(ir_exec), .psr(psr),
    .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC), .enable_decode(enable_decode),
    .enable_execute(enable_execute), .enable_writeback(enable_writeback), .br_taken(br_taken),
    .mem_state(mem_state), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2)
  );

  always #5 clock = ~clock;

  assign got_vec = {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback,
                    br_taken, mem_state, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};

  // Reference model: three pipeline slots (decode/execute/writeback), a bubble
  // count, and the remaining memory phases of the current access as a queue.
  bit sv [1:3];
  bit sb [2:3];
  bit m_run, m_raw_done;
  int m_bub;
  int mq[$];
  bit e_fetch, e_upc, e_dec, e_exe, e_wb, e_brt, e_adv, e_raw;
  bit [3:0] e_byp;
  int e_ms;

  function automatic int opc(input logic [15:0] x);
    return int'(x[15:12]);
  endfunction

  function automatic logic [11:0] exp_vec();
    return {e_fetch, e_upc, e_dec, e_exe, e_wb, e_brt, 2'(e_ms), e_byp};
  endfunction

  task automatic model_reset();
    sv = '{0, 0, 0};
    sb = '{0, 0};
    m_run = 0; m_raw_done = 0; m_bub = 0;
    mq.delete();
  endtask

  task automatic model_eval();
    bit pre, hv, xalu, xld, tworeg, a1, a2, m1, m2;
    pre    = complete_instr && (mq.size() == 0);
    xalu   = opc(ir_exec) inside {1, 5, 9};
    xld    = opc(ir_exec) inside {2, 6, 10};
    tworeg = (opc(ir) inside {1, 5}) && !ir[5];
    a1 = xalu && (ir_exec[11:9] == ir[8:6]);
    a2 = xalu && tworeg && (ir_exec[11:9] == ir[2:0]);
    m1 = xld && (ir_exec[11:9] == ir[8:6]);
    m2 = xld && tworeg && (ir_exec[11:9] == ir[2:0]);
    hv = pre && sv[2];
`ifdef LC3_CTRL_BYPASS_EN
    e_byp = hv ? {a1, a2, m1, m2} : 4'b0000;
    e_raw = 0;
`else
    e_byp = 4'b0000;
    e_raw = hv && (a1 || a2 || m1 || m2) && !m_raw_done;
`endif
    e_adv   = pre && !e_raw;
    e_fetch = e_adv && m_run && (m_bub == 0);
    e_dec   = e_adv && sv[1];
    e_exe   = e_adv && sv[2];
    e_wb    = (e_adv && sv[3]) || (mq.size() != 0 && mq[0] == 0 && complete_data);
    e_brt   = e_adv && sb[3] &&
              (opc(ir_exec) == 12 || (opc(ir_exec) == 0 && (ir_exec[11:9] & psr) != 3'b000));
    e_upc   = e_fetch || e_brt;
    e_ms    = (mq.size() == 0) ? 3 : mq[0];
  endtask

  task automatic model_commit();
    bit trig;
    if (!reset) begin
      model_reset();
      return;
    end
    m_run = 1;
    if (e_adv) begin
      trig  = e_dec && (opc(instr_dout) inside {0, 12});
      sv[3] = sv[2]; sb[3] = sb[2];
      sv[2] = sv[1]; sb[2] = trig;
      sv[1] = e_fetch;
      m_bub = trig ? int'(BB) : (m_bub > 0 ? m_bub - 1 : 0);
    end
    if (e_raw) m_raw_done = 1;
    else if (e_adv) m_raw_done = 0;
    if (mq.size() == 0) begin
      if (e_exe) begin
        case (opc(ir))
          2, 6:    mq = {0};
          3, 7:    mq = {2};
          10:      mq = {1, 0};
          11:      mq = {1, 2};
          default: ;
        endcase
      end
    end else if (complete_data) begin
      void'(mq.pop_front());
    end
  endtask

  task automatic sample();
    @(negedge clock);
    model_eval();
  endtask

  task automatic advance_clk();
    model_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance_clk();
    end
  endtask

  task automatic test_reset();
    #1;
    complete_instr = 1; complete_data = 0; psr = 3'b000;
    instr_dout = NEUT; ir = NEUT; ir_exec = NEUT;
    reset = 0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      sample();
      tests++;
      if (got_vec !== 12'h030) begin
        fails++;
        $display("FAIL reset_values cyc=%0d got=%03h exp=030", i, got_vec);
      end
      advance_clk();
    end
  endtask

  task automatic test_fill();
    logic [3:0] fill_exp [0:4];
    fill_exp[0] = 4'b0000; fill_exp[1] = 4'b1000; fill_exp[2] = 4'b1100;
    fill_exp[3] = 4'b1110; fill_exp[4] = 4'b1111;
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      sample();
      tests++;
      if ({enable_fetch, enable_decode, enable_execute, enable_writeback, mem_state} !==
          {fill_exp[k], 2'd3}) begin
        fails++;
        $display("FAIL fill cyc=%0d got=%b/%0d exp=%b/3", k,
                 {enable_fetch, enable_decode, enable_execute, enable_writeback}, mem_state, fill_exp[k]);
      end
      advance_clk();
    end
  endtask

  task automatic test_ldi();
    int cd_seq [0:5] = '{0, 1, 0, 0, 1, 0};
    int ms_seq [0:5] = '{1, 1, 0, 0, 0, 3};
    logic [4:0] en_seq [0:5];
    int wb_count = 0;
    en_seq = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b11111};
    ir = 16'hA200;
    sample();
    tests++;
    if (enable_execute !== 1'b1 || mem_state !== 2'd3) begin
      fails++;
      $display("FAIL ldi_entry got exe=%b ms=%0d exp exe=1 ms=3", enable_execute, mem_state);
    end
    advance_clk();
    ir = NEUT;
    for (int c = 0; c < 6; c++) begin
      complete_data = cd_seq[c][0];
      sample();
      if (c < 5 && enable_writeback) wb_count++;
      tests++;
      if (mem_state !== 2'(ms_seq[c]) ||
          {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback} !== en_seq[c]) begin
        fails++;
        $display("FAIL ldi_stall cyc=%0d got ms=%0d en=%b exp ms=%0d en=%b", c, mem_state,
                 {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback},
                 ms_seq[c], en_seq[c]);
      end
      advance_clk();
    end
    complete_data = 0;
    tests++;
    if (wb_count != 1) begin
      fails++;
      $display("FAIL ldi_wb_pulses got=%0d exp=1", wb_count);
    end
  endtask

  task automatic test_br_taken();
    logic [15:0] br_instr [0:1] = '{16'h0E05, 16'h0405};
    logic [2:0]  br_psr   [0:1] = '{3'b010, 3'b001};
    bit          taken    [0:1] = '{1, 0};
    logic [2:0]  exp;
    for (int b = 0; b < 2; b++) begin
      psr = br_psr[b];
      for (int k = 0; k < 5; k++) begin
        instr_dout = (k == 0) ? br_instr[b] : NEUT;
        ir         = (k == 1) ? br_instr[b] : NEUT;
        ir_exec    = (k == 2) ? br_instr[b] : NEUT;
        case (k)
          0, 4:    exp = 3'b110;
          2:       exp = taken[b] ? 3'b011 : 3'b000;
          default: exp = 3'b000;
        endcase
        sample();
        tests++;
        if ({enable_fetch, enable_updatePC, br_taken} !== exp) begin
          fails++;
          $display("FAIL br case=%0d t+%0d got fetch/upc/brt=%b exp=%b", b, k,
                   {enable_fetch, enable_updatePC, br_taken}, exp);
        end
        advance_clk();
      end
    end
    psr = 3'b000;
  endtask

  task automatic test_raw();
    logic [15:0] rx [0:2] = '{16'h1261, 16'h2400, 16'h5A3F};
    logic [15:0] ri [0:2] = '{16'h1442, 16'h1442, 16'h1B45};
    logic [3:0]  rb [0:2] = '{4'b1000, 4'b0001, 4'b1100};
    logic [7:0]  exp;
    for (int r = 0; r < 3; r++) begin
      ir_exec = rx[r]; ir = ri[r];
      for (int k = 0; k < 2; k++) begin
`ifdef LC3_CTRL_BYPASS_EN
        exp = {4'b1111, rb[r]};
`else
        exp = (k == 0) ? 8'h00 : 8'hF0;
`endif
        sample();
        tests++;
        if ({enable_fetch, enable_decode, enable_execute, enable_writeback,
             bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} !== exp) begin
          fails++;
          $display("FAIL raw case=%0d cyc=%0d got=%b exp=%b", r, k,
                   {enable_fetch, enable_decode, enable_execute, enable_writeback,
                    bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2}, exp);
        end
        advance_clk();
      end
    end
    ir_exec = NEUT; ir = NEUT;
  endtask

  task automatic test_reset_mid_stall();
    ir = 16'h3000;
    sample();
    advance_clk();
    ir = NEUT;
    sample();
    tests++;
    if (mem_state !== 2'd2 || enable_fetch !== 1'b0) begin
      fails++;
      $display("FAIL write_stall got ms=%0d fetch=%b exp ms=2 fetch=0", mem_state, enable_fetch);
    end
    advance_clk();
    reset = 0;
    model_reset();
    sample();
    tests++;
    if (got_vec !== 12'h030) begin
      fails++;
      $display("FAIL reset_mid_stall got=%03h exp=030", got_vec);
    end
    advance_clk();
    test_fill();
  endtask

  task automatic test_random();
    int xops [0:8] = '{0, 1, 5, 9, 2, 6, 10, 12, 13};
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(199) != 0);
      if (!reset) model_reset();
      complete_instr = ($urandom_range(7) != 0);
      complete_data  = 1'($urandom_range(1));
      instr_dout     = 16'($urandom);
      ir             = 16'($urandom);
      ir_exec        = {4'(xops[$urandom_range(8)]), 12'($urandom)};
      psr            = 3'($urandom);
      sample();
      tests++;
      if (got_vec !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%03h exp=%03h", c, got_vec, exp_vec());
      end
      advance_clk();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ldi();
    test_br_taken();
    idle(3);
    test_raw();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_controller.md
# lc3_pipe_controller

Pipeline sequencer for the LC-3 core: generates the per-stage enables that gate fetch, decode, execute and writeback. It stalls the pipeline on instruction- and data-memory handshakes, inserts bubbles for control transfers, and drives the data-memory access state. It sits beside the decode stage and drives that stage's `enable_decode` input. It consumes the fetched instruction (`instr_dout`, which is the decode stage's `dout`) and the instructions held downstream.

## Interface
- `BR_BUBBLE`, default 3: number of fetch bubbles inserted after a BR/JMP enters decode (legal range 1..7).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `complete_instr`  in  1  instruction memory has valid data this cycle.
- `complete_data`  in  1  data memory access finished this cycle.
- `instr_dout`  in  16  fetched instruction presented to decode.
- `ir`  in  16  instruction at execute input (decode output).
- `ir_exec`  in  16  instruction at execute output / writeback.
- `psr`  in  3  NZP condition flags.
- `enable_fetch`, `enable_updatePC`, `enable_decode`, `enable_execute`, `enable_writeback`  out  1 each  stage enables.
- `br_taken`  out  1  PC loads branch target.
- `mem_state`  out  2  0 = READ, 1 = INDIRECT, 2 = WRITE, 3 = IDLE.
- `bypass_alu_1`, `bypass_alu_2`, `bypass_mem_1`, `bypass_mem_2`  out  1 each  operand forwarding selects.

## Operation
- **Reset values:** all enables 0, `br_taken` 0, all bypass outputs 0, `mem_state` = 3, valid shift register `v[3:0]` = 0, bubble counter 0.
- **Valid shift register:**
  - `v[0]` is set when a fetch issues.
  - On each advance cycle, `v` shifts left.
  - `enable_decode` = `v[1]`, `enable_execute` = `v[2]`, `enable_writeback` = `v[3]`.
  - All enables are gated by `advance`.
- **Advance:** `advance` = `complete_instr` & (`mem_state` == 3) & !`raw_stall`. When `advance` is 0, all enables are 0 and `v` holds.
- **Fetch:** `enable_fetch` = `advance` & (bubble counter == 0). `enable_updatePC` = `enable_fetch` | `br_taken`.
- **Control hazard:**
  - Trigger: `enable_decode`=1 with `instr_dout[15:12]` ∈ {0000 BR, 1100 JMP}.
  - The bubble counter loads `BR_BUBBLE` and decrements on each advance cycle.
  - `br_taken` is asserted for one cycle, when that instruction is in `ir_exec`. Its value is 1 for JMP, and (`ir_exec[11:9]` & `psr`) != 0 for BR.
- **Memory FSM:**
  - Entry: with `enable_execute`=1 and `ir` opcode ∈ {LD 0010, LDR 0110} → READ; {ST 0011, STR 0111} → WRITE; {LDI 1010, STI 1011} → INDIRECT. The new state takes effect the next cycle.
  - On `complete_data`: INDIRECT → READ (LDI) or WRITE (STI); READ/WRITE → IDLE.
  - On the READ → IDLE exit, `enable_writeback`=1 for that cycle.
- **Bypass:**
  - `bypass_alu_1`: `ir_exec` opcode is ADD/AND/NOT and `ir_exec[11:9]` == `ir[8:6]`, with `enable_execute`=1.
  - `bypass_alu_2`: same condition against `ir[2:0]`, only when `ir` is ADD/AND with `ir[5]`=0.
  - `bypass_mem_1` / `bypass_mem_2`: same comparisons, with `ir_exec` a load (LD/LDR/LDI).

## Timing
- Pipeline fill after reset release with `complete_instr`=1: `enable_fetch` at cycle 1, `enable_decode` at cycle 2, `enable_execute` at cycle 3, `enable_writeback` at cycle 4.
- BR decoded in cycle t: `enable_fetch` is low for `BR_BUBBLE` advance cycles starting t+1; `br_taken` is evaluated at t+2.
- Memory stall: from the cycle after entry until the cycle `complete_data` returns to IDLE. During the stall, the bubble counter and `v` freeze.
- Memory stall and bubble together: the memory stall has priority; the branch is not lost.
- `complete_data` while IDLE: ignored.
- `complete_instr` low: full freeze, no state lost.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; the FSM goes to IDLE and the counter to 0.

## Configuration
- `LC3_CTRL_BYPASS_EN`:
  - **Defined:** bypass outputs computed as above; `raw_stall` = 0.
  - **Undefined:** all bypass outputs are tied to 0. `raw_stall` is asserted for one cycle whenever any bypass condition would have fired, inserting one bubble.

## Structure
- **Package `lc3_ctrl_pkg`:** opcode constants (or an opcode enum), `mem_state_t` enum (READ=0, INDIRECT=1, WRITE=2, IDLE=3), and helper functions `is_alu_op`, `is_load_op`, `is_mem_op`.
- **Sub-module `lc3_mem_fsm`:** memory FSM. Inputs: `clock`, `reset`, start and opcode class, `complete_data`. Outputs: `mem_state` and the writeback pulse.

## Test plan
- **Reset and fill:** release reset with `complete_instr`=1 → enables rise at cycles 1, 2, 3, 4; `mem_state`=3 throughout.
- **LDI:** `ir`=16'hA200 in execute; `complete_data` after 2 cycles, then again after 3 → `mem_state` 1 → 0 → 3; all enables 0 during the stall; one `enable_writeback` pulse on exit.
- **BR taken:** `instr_dout`=16'h0E05, `psr`=3'b010 → `enable_fetch` low for 3 cycles; `br_taken`=1 for one cycle; `enable_updatePC`=1 on that cycle.
- **RAW hazard:** `ir_exec`=16'h1261 (ADD R1,R1,#1), `ir`=16'h1442 (ADD R2,R1,R2).
  - With the macro defined → `bypass_alu_1`=1, no stall.
  - With the macro undefined → one cycle with all enables 0.
- **Reset mid-stall:** assert `reset` during a WRITE stall → outputs return to reset values immediately; fill sequence restarts after release.
